alu_result_tx: RTL and testbench

Return-path serializer for the UART ALU. Accepts one ALU result word plus its `{V, N, Z, P}` flag nibble through a valid/ready handshake. Frames them into a fixed byte packet and shifts the packet out on a single UART TX line, 8N1, LSB first. Sits between the ALU datapath (subtractor/adder with flags) and the board TX pin.

---
 rtl/alu_uart_pkg.sv | 25 ++
 rtl/uart_tx_byte.sv | 112 +++++++++++
 rtl/alu_result_tx.sv | 96 +++++++++
 tb/tb_alu_result_tx.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_uart_pkg.sv
// Shared definitions for the UART ALU return path: flag bit positions,
// default baud divisor, serializer states and packet sizing.
package alu_uart_pkg;

    localparam int FLAG_V = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_P = 0;

    // 100 MHz system clock, 115200 baud
    localparam int CLKS_PER_BIT_DEFAULT = 868;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    // Result bytes plus one flags byte plus one checksum byte.
    function automatic int pkt_bytes(input int n);
        return n / 8 + 2;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter, LSB first. A byte offered during the last cycle of a
// stop bit is taken immediately so consecutive bytes leave without idle bits.
module uart_tx_byte
    import alu_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_valid,
    output logic       byte_ready,
    input  logic [7:0] byte_data,
    output logic       tx
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    tx_state_t      state, state_n;
    logic [BW-1:0]  baud, baud_n;
    logic [2:0]     bit_idx, bit_n;
    logic [7:0]     shreg, shreg_n;
    logic           tx_n;
    logic           bit_end;

    assign bit_end = (baud == BAUD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= TX_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_idx <= bit_n;
            tx      <= tx_n;
        end
    end

    always_ff @(posedge clk) begin
        shreg <= shreg_n;
    end

    always_comb begin
        state_n    = state;
        baud_n     = baud;
        bit_n      = bit_idx;
        shreg_n    = shreg;
        tx_n       = tx;
        byte_ready = 1'b0;
        case (state)
            TX_IDLE: begin
                byte_ready = 1'b1;
                tx_n       = 1'b1;
                if (byte_valid) begin
                    state_n = TX_START;
                    baud_n  = '0;
                    shreg_n = byte_data;
                    tx_n    = 1'b0;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    state_n = TX_DATA;
                    baud_n  = '0;
                    bit_n   = '0;
                    tx_n    = shreg[0];
                end else begin
                    baud_n = baud + BW'(1);
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    baud_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = TX_STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_n   = bit_idx + 3'd1;
                        shreg_n = {1'b0, shreg[7:1]};
                        tx_n    = shreg[1];
                    end
                end else begin
                    baud_n = baud + BW'(1);
                end
            end
            TX_STOP: begin
                byte_ready = bit_end;
                if (bit_end) begin
                    baud_n = '0;
                    if (byte_valid) begin
                        state_n = TX_START;
                        shreg_n = byte_data;
                        tx_n    = 1'b0;
                    end else begin
                        state_n = TX_IDLE;
                        tx_n    = 1'b1;
                    end
                end else begin
                    baud_n = baud + BW'(1);
                end
            end
            default: begin
                state_n = TX_IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_result_tx.sv
// Frames one ALU result and its {V,N,Z,P} flags into a byte packet
// (result MSB byte first, flags, XOR checksum) and sends it over UART.
module alu_result_tx
    import alu_uart_pkg::*;
#(
    parameter int N            = 16,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_result,
    input  logic [3:0]   in_flags,
    output logic         tx,
    output logic         busy
);

    localparam int NB = pkt_bytes(N);
    localparam int NR = N / 8;
    localparam int IW = $clog2(NB);
    localparam logic [IW-1:0] IDX_LAST = IW'(NB - 1);

    logic [NB*8-1:0] frame;
    logic [NB*8-1:0] pkt;
    logic [7:0]      csum;
    logic [7:0]      flag_byte;
    logic [IW-1:0]   byte_idx;
    logic            active;
    logic            accept;
    logic            last;
    logic            byte_valid;
    logic            byte_ready;
    logic [7:0]      byte_data;

    assign accept    = in_valid && !active;
    assign in_ready  = !active;
    assign busy      = active;
    assign last      = (byte_idx == IDX_LAST);
    assign flag_byte = {4'b0000, in_flags[FLAG_V], in_flags[FLAG_N],
                        in_flags[FLAG_Z], in_flags[FLAG_P]};

    // Packet image built straight from the inputs; byte 0 sits in bits [7:0].
    always_comb begin
        frame = '0;
        csum  = flag_byte;
        for (int i = 0; i < NR; i++) begin
            frame[i*8 +: 8] = in_result[N-1-8*i -: 8];
            csum            = csum ^ in_result[N-1-8*i -: 8];
        end
        frame[NR*8 +: 8]     = flag_byte;
        frame[(NB-1)*8 +: 8] = csum;
    end

    // While idle the first byte goes straight to the transmitter, so the start
    // bit appears on the accepting edge; pkt then holds the remaining bytes.
    assign byte_valid = active ? !last : in_valid;
    assign byte_data  = active ? pkt[7:0] : frame[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active   <= 1'b0;
            byte_idx <= '0;
        end else if (accept) begin
            active   <= 1'b1;
            byte_idx <= '0;
        end else if (active && byte_ready) begin
            if (last) begin
                active   <= 1'b0;
                byte_idx <= '0;
            end else begin
                byte_idx <= byte_idx + IW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            pkt <= frame >> 8;
        end else if (active && byte_ready && !last) begin
            pkt <= pkt >> 8;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_byte (
        .clk       (clk),
        .rst       (rst),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .byte_data (byte_data),
        .tx        (tx)
    );

endmodule

// File: tb/tb_alu_result_tx.sv
// Bench for alu_result_tx: bit-centre UART receiver, fixed vectors, handshake
// and reset corner cases, and random words against a packet model.
module tb_alu_result_tx;

    localparam int N       = 16;
    localparam int CPB     = 4;
    localparam int NB      = 4;
    localparam int PKT_CYC = NB * 10 * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_result = '0;
    logic [3:0]  in_flags = '0;
    logic        in_ready;
    logic        tx;
    logic        busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  flags;
        logic [31:0] exp;
    } vec_t;

    alu_result_tx #(
        .N(N),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_result(in_result),
        .in_flags (in_flags),
        .tx       (tx),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected packet as {byte0, byte1, byte2, byte3}, byte0 sent first.
    function automatic logic [31:0] model_packet(input logic [15:0] r, input logic [3:0] f);
        int hi, lo, fb, cs;
        hi = int'(r) / 256;
        lo = int'(r) % 256;
        fb = int'(f);
        cs = hi ^ lo ^ fb;
        return {hi[7:0], lo[7:0], fb[7:0], cs[7:0]};
    endfunction

    // Returns just after the posedge that samples the handshake.
    task automatic wait_accept(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        else @(posedge clk);
    endtask

    // Called just after the accepting edge; ends at the negedge following
    // the edge that closes the last stop bit.
    task automatic recv_packet(input logic [31:0] exp, input bit hold_valid, input string tag);
        logic [7:0] rx [NB];
        bit frame_ok = 1'b1;
        bit busy_ok  = 1'b1;
        int slot, b, j;
        for (int k = 0; k < NB; k++) rx[k] = '0;
        for (int n = 0; n < PKT_CYC; n++) begin
            @(negedge clk);
            if (n == 0) begin
                check({tag, "_start_tx"}, {31'd0, tx}, 32'd0);
                if (!hold_valid) in_valid = 1'b0;
            end
            if (in_ready !== 1'b0 || busy !== 1'b1) busy_ok = 1'b0;
            if (n % CPB == CPB / 2) begin
                slot = n / CPB;
                b    = slot / 10;
                j    = slot % 10;
                if (j == 0) begin
                    if (tx !== 1'b0) frame_ok = 1'b0;
                end else if (j == 9) begin
                    if (tx !== 1'b1) frame_ok = 1'b0;
                end else begin
                    rx[b][j-1] = tx;
                end
            end
        end
        @(negedge clk);
        check({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_idle_tx"}, {31'd0, tx}, 32'd1);
        for (int k = 0; k < NB; k++) begin
            check($sformatf("%s_byte%0d", tag, k), {24'd0, rx[k]}, {24'd0, exp[31-8*k -: 8]});
        end
        check({tag, "_framing"}, {31'd0, frame_ok}, 32'd1);
        check({tag, "_busy_window"}, {31'd0, busy_ok}, 32'd1);
    endtask

    initial begin
        vec_t tbl [3];
        bit   ok;
        bit   quiet;
        logic [15:0] w1, w2, r;
        logic [3:0]  f1, f2, f;

        tbl[0] = '{res: 16'h0000, flags: 4'b0011, exp: 32'h00_00_03_03};
        tbl[1] = '{res: 16'h8000, flags: 4'b1100, exp: 32'h80_00_0C_8C};
        tbl[2] = '{res: 16'hB10E, flags: 4'b0100, exp: 32'hB1_0E_04_BB};

        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_reset_tx", {31'd0, tx}, 32'd1);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_result = tbl[i].res;
            in_flags  = tbl[i].flags;
            in_valid  = 1'b1;
            wait_accept(ok);
            if (ok) recv_packet(tbl[i].exp, 1'b0, $sformatf("vec%0d", i));
        end

        // Second word held on in_valid during the first packet.
        w1 = 16'h1234; f1 = 4'b0101;
        w2 = 16'hFEDC; f2 = 4'b1010;
        @(negedge clk);
        in_result = w1;
        in_flags  = f1;
        in_valid  = 1'b1;
        wait_accept(ok);
        if (ok) begin
            #1;
            in_result = w2;
            in_flags  = f2;
            recv_packet(model_packet(w1, f1), 1'b1, "vwb_first");
            @(posedge clk);
            recv_packet(model_packet(w2, f2), 1'b0, "vwb_second");
        end

        // Reset in the middle of byte 1's data bits.
        @(negedge clk);
        in_result = 16'hA5C3;
        in_flags  = 4'b1001;
        in_valid  = 1'b1;
        wait_accept(ok);
        if (ok) begin
            repeat (14 * CPB + 1) @(negedge clk);
            in_valid = 1'b0;
            check("mid_pkt_busy_before_reset", {31'd0, busy}, 32'd1);
            #1 rst = 1'b1;
            #1;
            check("reset_mid_tx", {31'd0, tx}, 32'd1);
            check("reset_mid_in_ready", {31'd0, in_ready}, 32'd1);
            repeat (2) @(negedge clk);
            rst = 1'b0;
            quiet = 1'b1;
            for (int n = 0; n < 60; n++) begin
                @(negedge clk);
                if (tx !== 1'b1 || in_ready !== 1'b1) quiet = 1'b0;
            end
            check("reset_no_resume", {31'd0, quiet}, 32'd1);
            @(negedge clk);
            in_result = 16'h5A3C;
            in_flags  = 4'b0110;
            in_valid  = 1'b1;
            wait_accept(ok);
            if (ok) recv_packet(model_packet(16'h5A3C, 4'b0110), 1'b0, "after_reset");
        end

        for (int i = 0; i < 200; i++) begin
            r = 16'($urandom);
            f = 4'($urandom_range(0, 15));
            @(negedge clk);
            in_result = r;
            in_flags  = f;
            in_valid  = 1'b1;
            wait_accept(ok);
            if (!ok) break;
            recv_packet(model_packet(r, f), 1'b0, "rand");
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
